// File: rtl/pulse_period_meter.sv
// Measures the rising-edge-to-rising-edge period of a strobe in sys_clk cycles,
// declares lock after LOCK_CNT identical periods and flags loss of pulses.
module pulse_period_meter #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 50000,
  parameter int SYNC_EN  = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, MEASURE, TRACK} state_t;

  localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       LOCK_V = 4'(LOCK_CNT);

  state_t           state;
  logic             s2, s3, edge_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] meas;
  logic [3:0]       match;

  generate
    if (SYNC_EN != 0) begin : g_sync
      logic s1;
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
        end else begin
          s1 <= pulse_in;
          s2 <= s1;
        end
      end
    end else begin : g_nosync
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) s2 <= 1'b0;
        else            s2 <= pulse_in;
      end
    end
  endgenerate

  // The edge flag is registered so latency is fixed and the FSM sees a clean flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s3     <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      s3     <= s2;
      edge_r <= s2 & ~s3;
    end
  end

  assign meas = cnt + CNT_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      match        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (edge_r) state <= MEASURE;
        end
        MEASURE, TRACK: begin
          if (edge_r) begin
            cnt          <= '0;
            period       <= meas;
            period_valid <= 1'b1;
            state        <= TRACK;
            if (state == MEASURE) begin
              match <= 4'd1;
            end else if (meas == period) begin
              if (match < LOCK_V) match <= match + 4'd1;
              if (match >= LOCK_V - 4'd1) locked <= 1'b1;
            end else begin
              match  <= 4'd1;
              locked <= 1'b0;
            end
          end else if (cnt == TO_M1) begin
            // An edge on the threshold cycle wins; only a missing edge times out.
            timeout_err <= 1'b1;
            period      <= '0;
            locked      <= 1'b0;
            match       <= '0;
            cnt         <= '0;
            state       <= IDLE;
          end else if (cnt != TO_V) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: one stimulus drives a synchronised (SYNC_EN=1)
// and an unsynchronised (SYNC_EN=0) instance, checked against a queued model.
module tb_pulse_period_meter;

  localparam int CNT_W    = 16;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 20;
  localparam int W        = 50;  // {due[31:0], is_timeout, locked, period[15:0]}

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             pulse_in = 1'b0;
  logic [CNT_W-1:0] period1, period0;
  logic             pv1, pv0, lk1, lk0, to1, to0;

  pulse_period_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .SYNC_EN(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pulse_in(pulse_in),
    .period(period1), .period_valid(pv1), .locked(lk1), .timeout_err(to1)
  );

  pulse_period_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .SYNC_EN(0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pulse_in(pulse_in),
    .period(period0), .period_valid(pv0), .locked(lk0), .timeout_err(to0)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];

  // model state, in the domain of the clock edge that first samples pulse_in high
  bit   prev_s;
  int   m_state;  // 0 idle, 1 reference seen, 2 tracking
  int   last_k, m_period, run;
  logic [CNT_W-1:0] ep1, ep0;
  logic el1, el0;
  bit   hit;
  logic [W-1:0] ev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_ev(input int due, input bit is_to, input bit lck, input int per);
    return {32'(due), is_to, lck, CNT_W'(per)};
  endfunction

  task automatic push_ev(input int k, input bit is_to, input bit lck, input int per);
    exp_q1.push_back(mk_ev(k + 3, is_to, lck, per));
    exp_q0.push_back(mk_ev(k + 2, is_to, lck, per));
  endtask

  task automatic cmp_out(input string tag, input bit h, input logic [W-1:0] e,
                         input logic pv, input logic to, input logic [CNT_W-1:0] per, input logic lk,
                         inout logic [CNT_W-1:0] ep, inout logic el);
    bit e_pv, e_to;
    e_pv = h && !e[CNT_W+1];
    e_to = h && e[CNT_W+1];
    if (e_pv) begin
      ep = e[CNT_W-1:0];
      el = e[CNT_W];
    end
    if (e_to) begin
      ep = '0;
      el = 1'b0;
    end
    chk({tag, ".period_valid"}, 32'(pv), 32'(e_pv));
    chk({tag, ".timeout_err"}, 32'(to), 32'(e_to));
    chk({tag, ".period"}, 32'(per), 32'(ep));
    chk({tag, ".locked"}, 32'(lk), 32'(el));
  endtask

  // Model + scoreboard: push expected events on sampled edges, pop when due.
  always @(posedge sys_clk) begin
    cyc++;
    if (!sys_rst_n) begin
      prev_s = 1'b0;
      m_state = 0;
      m_period = 0;
      run = 0;
      exp_q1.delete();
      exp_q0.delete();
      ep1 = '0; ep0 = '0; el1 = 1'b0; el0 = 1'b0;
    end else begin
      if (pulse_in && !prev_s) begin
        if (m_state == 0) begin
          m_state = 1;
        end else begin
          run = (m_state == 1) ? 1 : ((cyc - last_k == m_period) ? run + 1 : 1);
          m_period = cyc - last_k;
          m_state = 2;
          push_ev(cyc, 1'b0, run >= LOCK_CNT, m_period);
        end
        last_k = cyc;
      end else if (m_state != 0 && cyc - last_k == TIMEOUT) begin
        push_ev(cyc, 1'b1, 1'b0, 0);
        m_state = 0;
        m_period = 0;
        run = 0;
      end
      prev_s = pulse_in;
    end
    #1;
    hit = (exp_q1.size() > 0) && (exp_q1[0][W-1 -: 32] == 32'(cyc));
    ev = hit ? exp_q1.pop_front() : '0;
    cmp_out("sync1", hit, ev, pv1, to1, period1, lk1, ep1, el1);
    hit = (exp_q0.size() > 0) && (exp_q0[0][W-1 -: 32] == 32'(cyc));
    ev = hit ? exp_q0.pop_front() : '0;
    cmp_out("sync0", hit, ev, pv0, to0, period0, lk0, ep0, el0);
  end

  task automatic pulses(input int p, input int n);
    repeat (n) begin
      pulse_in = 1'b1;
      @(negedge sys_clk);
      pulse_in = 1'b0;
      repeat (p - 1) @(negedge sys_clk);
    end
  endtask

  task automatic idle(input int c);
    pulse_in = 1'b0;
    repeat (c) @(negedge sys_clk);
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    pulse_in = 1'b0;
    #1;
    chk({tag, ".period1"}, 32'(period1), 0);
    chk({tag, ".locked1"}, 32'(lk1), 0);
    chk({tag, ".pv1"}, 32'(pv1), 0);
    chk({tag, ".to1"}, 32'(to1), 0);
    chk({tag, ".period0"}, 32'(period0), 0);
    chk({tag, ".locked0"}, 32'(lk0), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int rp;
    // reset held while the input toggles
    repeat (6) begin
      @(negedge sys_clk);
      pulse_in = ~pulse_in;
    end
    @(negedge sys_clk);
    pulse_in = 1'b0;
    sys_rst_n = 1'b1;
    idle(2);

    pulses(5, 8);          // acquire lock on 5
    pulses(7, 6);          // change to 7: drop, then re-lock
    idle(30);              // loss of pulses -> timeout
    pulses(5, 3);          // resume: first edge is reference only
    repeat (10) begin      // fastest input: period 2
      pulse_in = ~pulse_in;
      @(negedge sys_clk);
    end
    pulse_in = 1'b1;       // level held high: one edge then timeout
    repeat (30) @(negedge sys_clk);
    idle(25);
    pulses(20, 4);         // edges landing on the timeout threshold
    pulses(21, 3);         // one cycle too slow: repeated timeouts
    idle(25);
    pulses(6, 6);
    async_reset_check("midop_reset");
    pulses(6, 6);          // normal re-acquisition
    for (int i = 0; i < 3; i++) begin
      rp = $urandom_range(9, 2);
      pulses(rp, 5);
    end
    idle(30);

    chk("queue1_drained", 32'(exp_q1.size()), 0);
    chk("queue0_drained", 32'(exp_q0.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
